// File: rtl/startstop_input_conditioner.sv
// startstop_input_conditioner
//   Input stage for the two-mode timer. Synchronises and debounces the raw
//   active-low StartStop button and the ModeSel/TimeControl switches, and
//   produces single-cycle event pulses for the timer core.
//
// Ports
//   CLK_50MHz       in   sole clock, rising edge
//   rst             in   synchronous active-high reset
//   StartStop       in   raw button, async, 0 = pressed
//   ModeSel         in   raw mode switch, async
//   TimeControl[2:0] in  raw duration switches, async
//   Pressed         out  debounced button level, 1 = pressed
//   PressPulse      out  one-cycle pulse on debounced press
//   ReleasePulse    out  one-cycle pulse on debounced release
//   LongPulse       out  one-cycle pulse once per press held LONG_CYCLES
//   ModeSelOut      out  debounced ModeSel
//   TimeControlOut  out  debounced TimeControl
//   CfgChange       out  one-cycle pulse when the debounced config changes
//
// Build option
//   LONGPRESS_EN    when defined, the long-press detector is built;
//                   otherwise LongPulse is tied low.

module startstop_input_conditioner #(
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic       CLK_50MHz,
  input  logic       rst,
  input  logic       StartStop,
  input  logic       ModeSel,
  input  logic [2:0] TimeControl,
  output logic       Pressed,
  output logic       PressPulse,
  output logic       ReleasePulse,
  output logic       LongPulse,
  output logic       ModeSelOut,
  output logic [2:0] TimeControlOut,
  output logic       CfgChange
);

  localparam int BW = $clog2(DEB_CYCLES);

  if (DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("DEB_CYCLES and LONG_CYCLES must both be at least 2");
  end

  logic          btn_s1_q, btn_s1_d;
  logic          btn_s2_q, btn_s2_d;
  logic [3:0]    cfg_s1_q, cfg_s1_d;
  logic [3:0]    cfg_s2_q, cfg_s2_d;
  logic [3:0]    cfg_prev_q, cfg_prev_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          pressed_q, pressed_d;
  logic          press_pulse_q, press_pulse_d;
  logic          release_pulse_q, release_pulse_d;
  logic [BW-1:0] ccnt_q, ccnt_d;
  logic [3:0]    cfg_out_q, cfg_out_d;
  logic          cfg_change_q, cfg_change_d;
  logic          cfg_init_q, cfg_init_d;
  logic          btn_lvl;
  logic          cfg_pending;

  always_comb begin
    btn_s1_d   = StartStop;
    btn_s2_d   = btn_s1_q;
    cfg_s1_d   = {ModeSel, TimeControl};
    cfg_s2_d   = cfg_s1_q;
    cfg_prev_d = cfg_s2_q;

    // Button debounce: count consecutive cycles disagreeing with Pressed.
    btn_lvl         = ~btn_s2_q;
    bcnt_d          = '0;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    if (btn_lvl != pressed_q) begin
      if (bcnt_q == BW'(DEB_CYCLES - 1)) begin
        pressed_d       = btn_lvl;
        press_pulse_d   = btn_lvl;
        release_pulse_d = ~btn_lvl;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    // Config debounce. Before the first load every stable vector counts.
    // A change of the sampled vector restarts the run with this cycle as
    // its first, so only a vector that holds still is ever accepted.
    ccnt_d       = '0;
    cfg_out_d    = cfg_out_q;
    cfg_change_d = 1'b0;
    cfg_init_d   = cfg_init_q;
    cfg_pending  = (cfg_s2_q != cfg_out_q) || !cfg_init_q;
    if (cfg_pending) begin
      if (cfg_s2_q != cfg_prev_q) begin
        ccnt_d = BW'(1);
      end else if (ccnt_q == BW'(DEB_CYCLES - 1)) begin
        cfg_out_d    = cfg_s2_q;
        cfg_change_d = cfg_init_q;
        cfg_init_d   = 1'b1;
      end else begin
        ccnt_d = ccnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      btn_s1_q        <= 1'b1;
      btn_s2_q        <= 1'b1;
      cfg_s1_q        <= '0;
      cfg_s2_q        <= '0;
      cfg_prev_q      <= '0;
      bcnt_q          <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      ccnt_q          <= '0;
      cfg_out_q       <= '0;
      cfg_change_q    <= 1'b0;
      cfg_init_q      <= 1'b0;
    end else begin
      btn_s1_q        <= btn_s1_d;
      btn_s2_q        <= btn_s2_d;
      cfg_s1_q        <= cfg_s1_d;
      cfg_s2_q        <= cfg_s2_d;
      cfg_prev_q      <= cfg_prev_d;
      bcnt_q          <= bcnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      ccnt_q          <= ccnt_d;
      cfg_out_q       <= cfg_out_d;
      cfg_change_q    <= cfg_change_d;
      cfg_init_q      <= cfg_init_d;
    end
  end

  assign Pressed        = pressed_q;
  assign PressPulse     = press_pulse_q;
  assign ReleasePulse   = release_pulse_q;
  assign ModeSelOut     = cfg_out_q[3];
  assign TimeControlOut = cfg_out_q[2:0];
  assign CfgChange      = cfg_change_q;

`ifdef LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          done_q, done_d;
  logic          long_pulse_q, long_pulse_d;

  // lcnt restarts on the press edge and then counts held cycles; done
  // keeps LongPulse to a single firing per press.
  always_comb begin
    lcnt_d       = lcnt_q;
    done_d       = done_q;
    long_pulse_d = 1'b0;
    if (press_pulse_d) begin
      lcnt_d = '0;
    end else if (pressed_q && !done_q) begin
      if (lcnt_q == LW'(LONG_CYCLES - 1)) begin
        long_pulse_d = 1'b1;
        done_d       = 1'b1;
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end
    if (release_pulse_d) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      lcnt_q       <= '0;
      done_q       <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      lcnt_q       <= lcnt_d;
      done_q       <= done_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign LongPulse = long_pulse_q;
`else
  assign LongPulse = 1'b0;
`endif

endmodule

// File: tb/tb_startstop_input_conditioner.sv
module tb_startstop_input_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int HN   = 8192;
`ifdef LONGPRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       StartStop;
  logic       ModeSel;
  logic [2:0] TimeControl;
  logic       Pressed, PressPulse, ReleasePulse, LongPulse, ModeSelOut, CfgChange;
  logic [2:0] TimeControlOut;

  int checks = 0;
  int errors = 0;

  startstop_input_conditioner #(
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .CLK_50MHz     (clk),
    .rst           (rst),
    .StartStop     (StartStop),
    .ModeSel       (ModeSel),
    .TimeControl   (TimeControl),
    .Pressed       (Pressed),
    .PressPulse    (PressPulse),
    .ReleasePulse  (ReleasePulse),
    .LongPulse     (LongPulse),
    .ModeSelOut    (ModeSelOut),
    .TimeControlOut(TimeControlOut),
    .CfgChange     (CfgChange)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Each edge records the level presented to the
  // debouncers (the value two samples old). A level is accepted on the edge
  // that completes DEB consecutive non-reset edges all presenting the same
  // level, provided that level differs from the current output.
  bit         hr [HN];
  bit         hs [HN];
  logic [3:0] hc [HN];
  int         cyc = 0;
  bit         mb1 = 1'b1, mb2 = 1'b1;
  logic [3:0] mc1 = '0, mc2 = '0;
  bit         m_pressed = 0, m_press = 0, m_rel = 0, m_long = 0, m_cfg = 0, m_init = 0;
  logic [3:0] m_out = '0;
  int         m_p_edge = -100000;

  initial begin : model
    bit         d_s, prev_pressed, ok_b, ok_c;
    logic [3:0] d_c;
    int         j;
    forever begin
      @(posedge clk);
      cyc++;
      d_s = ~mb2;
      d_c = mc2;
      hr[cyc % HN] = rst;
      hs[cyc % HN] = d_s;
      hc[cyc % HN] = d_c;
      prev_pressed = m_pressed;
      m_press = 0; m_rel = 0; m_long = 0; m_cfg = 0;
      if (rst) begin
        mb1 = 1; mb2 = 1; mc1 = '0; mc2 = '0;
        m_pressed = 0; m_out = '0; m_init = 0; m_p_edge = -100000;
      end else begin
        ok_b = (d_s != m_pressed);
        ok_c = (d_c != m_out) || !m_init;
        for (int k = 0; k < DEB; k++) begin
          j = cyc - k;
          if (j < 1 || hr[j % HN] || hs[j % HN] != d_s) ok_b = 0;
          if (j < 1 || hr[j % HN] || hc[j % HN] != d_c) ok_c = 0;
        end
        if (LP_EN && prev_pressed && (cyc - m_p_edge == LONG)) m_long = 1;
        if (ok_b) begin
          m_pressed = d_s;
          m_press   = d_s;
          m_rel     = !d_s;
          if (d_s) m_p_edge = cyc;
        end
        if (ok_c) begin
          m_out  = d_c;
          m_cfg  = m_init;
          m_init = 1;
        end
        mb2 = mb1; mb1 = StartStop;
        mc2 = mc1; mc1 = {ModeSel, TimeControl};
      end
    end
  end

  logic [8:0] act_v, exp_v;
  assign act_v = {Pressed, PressPulse, ReleasePulse, LongPulse, ModeSelOut, TimeControlOut, CfgChange};
  assign exp_v = {m_pressed, m_press, m_rel, m_long, m_out, m_cfg};

  task automatic test_reset();
    int ncfg = 0;
    int first_at = -1;
    rst = 1; StartStop = 1; ModeSel = 0; TimeControl = 3'b001;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== 9'b0) begin
        errors++; $display("FAIL reset_outputs i=%0d got %b expected %b", i, act_v, 9'b0);
      end
    end
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL reset_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (CfgChange) ncfg++;
      if (first_at < 0 && TimeControlOut === 3'b001) first_at = i;
    end
    checks++;
    if (ncfg != 0 || first_at != 6) begin
      errors++; $display("FAIL init_load cfgchanges=%0d load_at=%0d expected 0 and 6", ncfg, first_at);
    end
  endtask

  task automatic test_press_release();
    int np = 0, nr = 0, p_at = -1, r_at = -1;
    StartStop = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL press_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (PressPulse) begin np++; p_at = i; end
    end
    checks++;
    if (np != 1 || p_at != 6 || Pressed !== 1'b1) begin
      errors++; $display("FAIL press_timing count=%0d at=%0d pressed=%b expected 1 6 1", np, p_at, Pressed);
    end
    StartStop = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL release_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (ReleasePulse) begin nr++; r_at = i; end
    end
    checks++;
    if (nr != 1 || r_at != 6 || Pressed !== 1'b0) begin
      errors++; $display("FAIL release_timing count=%0d at=%0d pressed=%b expected 1 6 0", nr, r_at, Pressed);
    end
  endtask

  task automatic test_bounce();
    int np = 0, p_at = -1;
    for (int i = 1; i <= 14; i++) begin
      StartStop = (i == 2 || i == 4) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL bounce_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (PressPulse) begin np++; p_at = i; end
    end
    checks++;
    if (np != 1 || p_at != 10) begin
      errors++; $display("FAIL bounce_press count=%0d at=%0d expected 1 10", np, p_at);
    end
    StartStop = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_long();
    int nl = 0, l_at = -1, np = 0;
    StartStop = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL long_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (LongPulse) begin nl++; l_at = i; end
      if (PressPulse) np++;
    end
    checks++;
    if (np != 1 || nl != (LP_EN ? 1 : 0) || (LP_EN && l_at != 22)) begin
      errors++; $display("FAIL long_press presses=%0d longs=%0d at=%0d expected 1 %0d 22", np, nl, l_at, LP_EN ? 1 : 0);
    end
    StartStop = 1;
    repeat (8) @(negedge clk);
    nl = 0;
    StartStop = 0;
    for (int i = 1; i <= 34; i++) begin
      if (i == 11) StartStop = 1;
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL short_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (LongPulse) nl++;
    end
    checks++;
    if (nl != 0) begin
      errors++; $display("FAIL short_press longs=%0d expected 0", nl);
    end
  endtask

  task automatic test_cfg();
    int nc = 0, c_at = -1;
    TimeControl = 3'b010;
    repeat (10) @(negedge clk);
    TimeControl = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL cfg_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (CfgChange) begin nc++; c_at = i; end
    end
    checks++;
    if (nc != 1 || c_at != 6 || TimeControlOut !== 3'b000) begin
      errors++; $display("FAIL cfg_change count=%0d at=%0d tc=%b expected 1 6 000", nc, c_at, TimeControlOut);
    end
    nc = 0;
    for (int i = 1; i <= 12; i++) begin
      ModeSel = (i <= 2);
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL glitch_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (CfgChange) nc++;
    end
    checks++;
    if (nc != 0 || ModeSelOut !== 1'b0) begin
      errors++; $display("FAIL cfg_glitch count=%0d mode=%b expected 0 0", nc, ModeSelOut);
    end
  endtask

  task automatic test_reset_held();
    int np = 0, p_at = -1;
    StartStop = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== 9'b0) begin
        errors++; $display("FAIL midreset_outputs i=%0d got %b expected %b", i, act_v, 9'b0);
      end
    end
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL midreset_model i=%0d got %b expected %b", i, act_v, exp_v);
      end
      if (PressPulse) begin np++; p_at = i; end
    end
    checks++;
    if (np != 1 || p_at != 6) begin
      errors++; $display("FAIL midreset_repress count=%0d at=%0d expected 1 6", np, p_at);
    end
    StartStop = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    int n = 0;
    while (n < 1500) begin
      rst = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) StartStop = ~StartStop;
      if ($urandom_range(0, 4) == 0) ModeSel = ~ModeSel;
      if ($urandom_range(0, 4) == 0) TimeControl = 3'($urandom_range(0, 7));
      len = rst ? $urandom_range(1, 2) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        n++;
        checks++;
        if (act_v !== exp_v) begin
          errors++; $display("FAIL random_model cyc=%0d got %b expected %b", cyc, act_v, exp_v);
        end
      end
    end
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random_tail cyc=%0d got %b expected %b", cyc, act_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1; StartStop = 1; ModeSel = 0; TimeControl = 3'b001;
    test_reset();
    test_press_release();
    test_bounce();
    test_long();
    test_cfg();
    test_reset_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
